// File: rtl/wisc_mem_pkg.sv
// wisc_mem_pkg: shared types and constants for the WISC-S15 data-memory
// responder and its storage array.
//   state_t      - responder FSM states (IDLE, WAIT, RESP)
//   WORD_W       - data word width
//   CNT_W        - latency counter width (LAT range 0..15)
//   ERR_DATA_DEF - default load data for out-of-range reads
//   in_range()   - true when a 16-bit word address falls inside the storage
package wisc_mem_pkg;

   localparam int          WORD_W       = 16;
   localparam int          CNT_W        = 4;
   localparam logic [15:0] ERR_DATA_DEF = 16'hDEAD;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Upper address bits above the storage index must all be zero.
   function automatic logic in_range(input logic [15:0] a, input int aw);
      return (a >> aw) == '0;
   endfunction

endpackage

// File: rtl/wisc_dmem_array.sv
// wisc_dmem_array: DEPTH x WORD_W register storage, no reset.
//   clk   - write clock
//   we    - write enable, write happens on posedge clk
//   waddr - write index
//   wdata - write data
//   raddr - read index (combinational read)
//   rdata - read data
module wisc_dmem_array
   import wisc_mem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/wisc_dmem_responder.sv
// wisc_dmem_responder: memory side of the WISC-S15 load/store req/ack link.
// Accepts one word request, waits LAT cycles, then completes with a
// single-cycle ack.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   req       - request valid, held by the core until ack
//   we        - 1 = store, 0 = load (sampled at acceptance)
//   addr      - word address (sampled at acceptance)
//   wdata     - store data (sampled at acceptance)
//   rdata     - load data, valid in the ack cycle and held afterwards
//   ack       - one-cycle completion pulse
//   busy      - high from the cycle after acceptance through the ack cycle
//   err       - high with ack when the address is outside the storage
//   state_dbg - current FSM state (state_t encoding)
//
// Handshake: a request is accepted on a posedge where the FSM is IDLE and
// req=1. It completes with ack=1 for exactly one cycle; req is ignored during
// that ack cycle, so a core that keeps req high past ack issues a new request
// which is accepted on the following IDLE edge.
module wisc_dmem_responder
   import wisc_mem_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter int          LAT      = 2,
   parameter logic [15:0] ERR_DATA = ERR_DATA_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err,
   output logic [1:0]  state_dbg
);

   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              cap_we;
   logic [15:0]       cap_addr;
   logic [15:0]       cap_wdata;

   logic              go_resp;
   logic              cur_we;
   logic [15:0]       cur_addr;
   logic [15:0]       cur_wdata;
   logic              cur_ok;
   logic              mem_we;
   logic [15:0]       mem_rdata;

   // With LAT=0 the completing edge is the acceptance edge itself, so the
   // live inputs are used there; otherwise the captured copy is used.
   always_comb begin
      cur_we    = cap_we;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      if (state == IDLE) begin
         cur_we    = we;
         cur_addr  = addr;
         cur_wdata = wdata;
      end
      go_resp = ((state == IDLE) && req && (LAT_C == '0)) ||
                ((state == WAIT) && (cnt == CNT_W'(1)));
      cur_ok  = in_range(cur_addr, ADDR_W);
      // Stores commit on the edge entering RESP; out-of-range stores drop.
      mem_we  = go_resp && cur_we && cur_ok;
   end

   wisc_dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cur_addr[ADDR_W-1:0]),
      .wdata (cur_wdata),
      .raddr (cur_addr[ADDR_W-1:0]),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rdata     <= '0;
         ack       <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  cap_we    <= we;
                  cap_addr  <= addr;
                  cap_wdata <= wdata;
                  cnt       <= LAT_C;
                  busy      <= 1'b1;
                  state     <= (LAT_C == '0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state <= RESP;
               end
            end
            RESP: begin
               // req is deliberately ignored here.
               busy  <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         if (go_resp) begin
            ack <= 1'b1;
            err <= !cur_ok;
            if (!cur_we) begin
               rdata <= cur_ok ? mem_rdata : ERR_DATA;
            end
         end
      end
   end

   assign state_dbg = state;

endmodule
